dff_bank_seq: RTL and testbench
===============================

Name: dff_bank_seq

Overview:
- Sequencer/arbiter that shares one W-bit bank of clear/set-capable flops (udp_dff-style cells, active-low clear/set, timing NOTIFIER) among N requesters.
- Grants one requester at a time and drives the bank's load/clear/set strobes.
- Waits for the cells to settle, then checks the result against the NOTIFIER and bank readback.
- On a violation it retries; after the retry limit it reports an error.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, bank width in bits
- SETTLE_CYC, 2, cycles waited after a strobe before checking (1..15)
- MAX_RETRY, 2, retries after a violation before reporting an error (0..7)

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-high reset
- req  in  N  per-requester request; held until that requester's done or err
- op  in  2*N  per-requester opcode (slice i = op[2i+1:2i]): 00 load, 01 clear, 10 set, 11 read
- wdata  in  W*N  per-requester load data (slice i = wdata[W*i+W-1:W*i])
- gnt  out  N  one-hot grant to the active requester
- done  out  N  1-cycle success pulse to the granted requester
- err  out  N  1-cycle failure pulse to the granted requester
- rdata  out  W  bank value captured in CHECK for a read; holds until the next read
- busy  out  1  high whenever state is not IDLE
- bank_d  out  W  data to the bank
- bank_ld  out  1  load enable, one cycle
- bank_clr_  out  1  active-low clear strobe
- bank_set_  out  1  active-low set strobe
- bank_q  in  W  bank readback
- notifier  in  1  timing-violation flag from the bank cells

Behaviour:
- Reset (async, clr=1):
  - state IDLE
  - gnt=0, done=0, err=0, busy=0
  - rdata=0, bank_d=0, bank_ld=0
  - bank_clr_=1, bank_set_=1
  - round-robin pointer=0, retry count=0
  - Reset mid-operation abandons the operation with no done/err. Strobes deassert immediately, asynchronously.
- IDLE:
  - If any req bit is set, the winner is the first set bit at or after the pointer, wrapping.
  - Latch the winner's op and wdata, assert gnt, go to DRIVE.
- DRIVE (1 cycle):
  - load: bank_ld=1, bank_d=latched data.
  - clear: bank_clr_=0.
  - set: bank_set_=0.
  - read: no strobe.
  - Then go to SETTLE; a read goes straight to CHECK.
- SETTLE: count SETTLE_CYC cycles, then go to CHECK.
- Violation tracking:
  - A sticky violation flag is set if notifier=1 in any DRIVE or SETTLE cycle.
  - notifier in CHECK or IDLE is ignored.
- CHECK (1 cycle):
  - Expected bank_q: load = latched data, clear = all zeros, set = all ones.
  - Pass (no violation, bank_q matches, or op is read): pulse done[gnt]; a read also captures bank_q into rdata.
  - Fail (violation or mismatch) with retries < MAX_RETRY: increment retries, clear the flag, return to DRIVE. gnt stays high, no pulse.
  - Fail with retries = MAX_RETRY: pulse err[gnt].
  - On done or err: go to IDLE, clear retries, set pointer to winner+1 mod N.
- gnt is high from DRIVE through CHECK and drops in the cycle after CHECK.
- Only one strobe is active at any time; strobes are never active outside DRIVE.
- Latency from the first clock edge that samples req in IDLE: done arrives 2+SETTLE_CYC cycles later (read: 2 cycles).
- Next grant: no earlier than one IDLE cycle after CHECK.
- A requester dropping req mid-operation does not abort the operation; done/err still pulses.
- Requests arriving while busy wait. Simultaneous requests are resolved by the round-robin pointer.

Optional Feature:
- Macro DFF_BANK_SEQ_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is held at 0.
- Undefined: round robin as described above.

Test Plan:
- Reset, then req[1]=1, op=load, wdata=8'hA5, bank model ideal:
  - bank_ld high exactly one cycle with bank_d=A5.
  - done[1] pulses 4 cycles after the request is sampled.
  - gnt=4'b0010 throughout.
- req=4'b1111, all doing clear, held: grants in order 0,1,2,3,0. Each has bank_clr_ low for one cycle, no overlap.
- Set op on req[2], notifier=1 during SETTLE of the first attempt only:
  - bank_set_ strobed twice.
  - done[2] pulses; err stays 0.
- Load on req[0], bank_q stuck at 8'h00, wdata=8'hFF:
  - Three DRIVE attempts (1 + MAX_RETRY).
  - err[0] pulses, no done.
  - Pointer advances to 1.
- Read on req[3] with bank_q=8'h3C: rdata=3C, done[3] pulses 2 cycles after sampling, no strobes.
- clr asserted during SETTLE of a load:
  - All outputs go to reset values asynchronously; no done/err.
  - After release, a held req is re-granted starting from pointer 0.

Source files
------------

// File: rtl/dff_bank_seq_if.sv
// Request/grant and flop-bank bundle for the shared dff bank sequencer.
// Latency: wires only, no state.
// Backpressure: requesters hold req until done/err; slave drives grants and bank strobes.
interface dff_bank_seq_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic [W-1:0]   rdata;
  logic           busy;
  logic [W-1:0]   bank_d;
  logic           bank_ld;
  logic           bank_clr_;
  logic           bank_set_;
  logic [W-1:0]   bank_q;
  logic           notifier;

  // Requester/bank side: drives requests and bank readback, observes grants and strobes.
  modport master (
    output req, op, wdata, bank_q, notifier,
    input  gnt, done, err, rdata, busy, bank_d, bank_ld, bank_clr_, bank_set_
  );

  // Sequencer side.
  modport slave (
    input  req, op, wdata, bank_q, notifier,
    output gnt, done, err, rdata, busy, bank_d, bank_ld, bank_clr_, bank_set_
  );
endinterface

// File: rtl/dff_bank_seq.sv
// Arbitrates N requesters onto one W-bit clear/set flop bank, strobes it, waits, verifies, retries.
// Latency: done/err 2+SETTLE_CYC edges after req is sampled in IDLE (read: 2); each retry adds 2+SETTLE_CYC.
// Backpressure: one op at a time; other requests wait held. DFF_BANK_SEQ_FIXED_PRIO_EN selects fixed priority.
module dff_bank_seq #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 2
) (
  input logic          clk,
  input logic          clr,
  dff_bank_seq_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] cur;
  logic [1:0]    cur_op;
  logic [W-1:0]  cur_dat;
  logic [3:0]    settle_cnt;
  logic [2:0]    retry_cnt;
  logic          viol;

  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic [1:0]    win_op;
  logic [W-1:0]  win_dat;
  logic [1:0]    drv_op;
  logic [W-1:0]  drv_dat;
  logic [W-1:0]  exp_q;
  logic          check_pass;
  int            idx;

  // Round-robin pick: first set req at or after ptr, wrapping; ptr stays 0 under fixed priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
    win_op  = bus.op[2*int'(win_idx) +: 2];
    win_dat = bus.wdata[W*int'(win_idx) +: W];
  end

  // Strobe source for the next DRIVE: fresh winner from IDLE, latched op on a retry.
  always_comb begin
    drv_op  = (state == IDLE) ? win_op  : cur_op;
    drv_dat = (state == IDLE) ? win_dat : cur_dat;
    case (cur_op)
      OP_LOAD: exp_q = cur_dat;
      OP_CLR:  exp_q = '0;
      OP_SET:  exp_q = '1;
      default: exp_q = cur_dat;
    endcase
    check_pass = (cur_op == OP_READ) || (!viol && (bus.bank_q == exp_q));
  end

  // Sequencer FSM with registered grant, pulses and bank strobes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      ptr           <= '0;
      cur           <= '0;
      cur_op        <= OP_LOAD;
      cur_dat       <= '0;
      settle_cnt    <= '0;
      retry_cnt     <= '0;
      viol          <= 1'b0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.err       <= '0;
      bus.busy      <= 1'b0;
      bus.rdata     <= '0;
      bus.bank_d    <= '0;
      bus.bank_ld   <= 1'b0;
      bus.bank_clr_ <= 1'b1;
      bus.bank_set_ <= 1'b1;
    end else begin
      bus.bank_ld   <= 1'b0;
      bus.bank_clr_ <= 1'b1;
      bus.bank_set_ <= 1'b1;
      bus.done      <= '0;
      bus.err       <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            cur           <= win_idx;
            cur_op        <= win_op;
            cur_dat       <= win_dat;
            bus.gnt       <= ONE << win_idx;
            bus.busy      <= 1'b1;
            viol          <= 1'b0;
            retry_cnt     <= '0;
            bus.bank_ld   <= (drv_op == OP_LOAD);
            bus.bank_clr_ <= (drv_op != OP_CLR);
            bus.bank_set_ <= (drv_op != OP_SET);
            if (drv_op == OP_LOAD) bus.bank_d <= drv_dat;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          if (bus.notifier) viol <= 1'b1;
          settle_cnt <= '0;
          state      <= (cur_op == OP_READ) ? CHECK : SETTLE;
        end
        SETTLE: begin
          if (bus.notifier) viol <= 1'b1;
          if (settle_cnt == 4'(SETTLE_CYC - 1)) state <= CHECK;
          else settle_cnt <= settle_cnt + 4'd1;
        end
        CHECK: begin
          if (check_pass || retry_cnt == 3'(MAX_RETRY)) begin
            if (check_pass) begin
              bus.done <= ONE << cur;
              if (cur_op == OP_READ) bus.rdata <= bus.bank_q;
            end else begin
              bus.err <= ONE << cur;
            end
            bus.gnt   <= '0;
            bus.busy  <= 1'b0;
            retry_cnt <= '0;
            state     <= IDLE;
`ifdef DFF_BANK_SEQ_FIXED_PRIO_EN
            ptr       <= '0;
`else
            ptr       <= (cur == PW'(N - 1)) ? '0 : cur + PW'(1);
`endif
          end else begin
            // Retry keeps the grant and re-strobes the latched op from a clean flag.
            retry_cnt     <= retry_cnt + 3'd1;
            viol          <= 1'b0;
            bus.bank_ld   <= (drv_op == OP_LOAD);
            bus.bank_clr_ <= (drv_op != OP_CLR);
            bus.bank_set_ <= (drv_op != OP_SET);
            if (drv_op == OP_LOAD) bus.bank_d <= drv_dat;
            state         <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_seq.sv
// Directed bench for dff_bank_seq with an ideal/stuck flop-bank model.
// Latency: checks done timing of 4 edges (load) and 2 edges (read) after sampling.
// Backpressure: requesters hold req until they see done/err.
module tb_dff_bank_seq;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  dff_bank_seq_if #(.N(N), .W(W)) bus ();

  dff_bank_seq #(.N(N), .W(W), .SETTLE_CYC(2), .MAX_RETRY(2)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;

  // Bank model: ideal flops, or a forced readback value when stuck is set.
  logic [W-1:0] bank_reg = '0;
  logic         stuck = 1'b0;
  logic [W-1:0] stuck_val = '0;
  always @(posedge clk) begin
    if (bus.bank_ld) bank_reg <= bus.bank_d;
    else if (!bus.bank_clr_) bank_reg <= '0;
    else if (!bus.bank_set_) bank_reg <= '1;
  end
  assign bus.bank_q = stuck ? stuck_val : bank_reg;

  // Strobe observation, sampled just before each rising edge.
  int ld_cnt = 0, clr_cnt = 0, set_cnt = 0, multi_cnt = 0, stray_cnt = 0, clr_run_bad = 0;
  logic [W-1:0] last_ld_dat = '0;
  logic prev_clr_low = 1'b0;
  always @(posedge clk) begin
    if (bus.bank_ld) begin
      ld_cnt++;
      last_ld_dat = bus.bank_d;
    end
    if (!bus.bank_clr_) clr_cnt++;
    if (!bus.bank_set_) set_cnt++;
    if ((int'(bus.bank_ld) + int'(!bus.bank_clr_) + int'(!bus.bank_set_)) > 1) multi_cnt++;
    if ((bus.bank_ld || !bus.bank_clr_ || !bus.bank_set_) && bus.gnt == '0) stray_cnt++;
    if (!bus.bank_clr_ && prev_clr_low) clr_run_bad++;
    prev_clr_low = !bus.bank_clr_;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clr = 1'b1;
    bus.req = '0; bus.op = '0; bus.wdata = '0; bus.notifier = 1'b0;
    stuck = 1'b0; stuck_val = '0;
    cyc(); cyc();
    clr = 1'b0;
  endtask

  // Releases requesters as they finish and waits, bounded, for the sequencer to go idle.
  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      cyc();
      bus.req = bus.req & ~(bus.done | bus.err);
      if (bus.req == '0 && bus.busy == 1'b0) ok = 1'b1;
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL drain_timeout: req=%b busy=%b, required req=0 busy=0", bus.req, bus.busy);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.req = '0; bus.op = '0; bus.wdata = '0; bus.notifier = 1'b0;
    cyc();
    vecs++;
    if ({bus.gnt, bus.done, bus.err, bus.busy} !== 13'b0) begin
      errs++;
      $display("FAIL reset_ctrl: gnt/done/err/busy=%b, required 0", {bus.gnt, bus.done, bus.err, bus.busy});
    end
    vecs++;
    if ({bus.rdata, bus.bank_d} !== 16'h0000) begin
      errs++;
      $display("FAIL reset_data: rdata=%h bank_d=%h, required 00 00", bus.rdata, bus.bank_d);
    end
    vecs++;
    if ({bus.bank_ld, bus.bank_clr_, bus.bank_set_} !== 3'b011) begin
      errs++;
      $display("FAIL reset_strobes: ld/clr_/set_=%b, required 011", {bus.bank_ld, bus.bank_clr_, bus.bank_set_});
    end
    clr = 1'b0;
    cyc(); cyc();
    vecs++;
    if ({bus.gnt, bus.busy} !== 5'b0) begin
      errs++;
      $display("FAIL reset_idle_noreq: gnt=%b busy=%b, required 0 0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_load();
    int done_at, gnt_bad, l0;
    logic [N-1:0] done_v, gnt_after;
    apply_reset();
    done_at = -1; gnt_bad = 0; done_v = '0; gnt_after = 'x;
    l0 = ld_cnt;
    bus.op = 8'b00000000;
    bus.wdata = 32'h0000A500;
    bus.req = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k <= 4 && bus.gnt !== 4'b0010) gnt_bad++;
      if (k == 5) gnt_after = bus.gnt;
      if (bus.done !== '0 && done_at < 0) begin
        done_at = k;
        done_v  = bus.done;
        bus.req = '0;
      end
    end
    vecs++;
    if (done_at != 5) begin
      errs++;
      $display("FAIL load_latency: done after %0d edges, required 4", done_at - 1);
    end
    vecs++;
    if (done_v !== 4'b0010) begin
      errs++;
      $display("FAIL load_done: done=%b, required 0010", done_v);
    end
    vecs++;
    if (gnt_bad != 0 || gnt_after !== 4'b0000) begin
      errs++;
      $display("FAIL load_gnt: %0d bad grant cycles, gnt after check=%b, required 0 and 0000", gnt_bad, gnt_after);
    end
    vecs++;
    if (ld_cnt - l0 != 1 || last_ld_dat !== 8'hA5) begin
      errs++;
      $display("FAIL load_strobe: %0d ld cycles data=%h, required 1 and a5", ld_cnt - l0, last_ld_dat);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [5];
    logic [N-1:0] prev, exp_g;
    int ng, c0, bad0;
    apply_reset();
    ng = 0; prev = '0;
    for (int i = 0; i < 5; i++) seq[i] = 'x;
    c0 = clr_cnt;
    bad0 = multi_cnt + stray_cnt + clr_run_bad;
    bus.op = 8'b01010101;
    bus.req = 4'b1111;
    for (int k = 0; k < 80 && ng < 5; k++) begin
      cyc();
      if (bus.gnt != '0 && prev == '0) begin
        seq[ng] = bus.gnt;
        ng++;
      end
      prev = bus.gnt;
    end
    bus.req = '0;
    drain();
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      vecs++;
      if (seq[i] !== exp_g) begin
        errs++;
        $display("FAIL rr_grant_%0d: gnt=%b, required %b", i, seq[i], exp_g);
      end
    end
    vecs++;
    if (clr_cnt - c0 != 5) begin
      errs++;
      $display("FAIL rr_clr_count: %0d clear strobe cycles, required 5", clr_cnt - c0);
    end
    vecs++;
    if (multi_cnt + stray_cnt + clr_run_bad - bad0 != 0) begin
      errs++;
      $display("FAIL rr_strobe_overlap: %0d overlapping/stray/long strobe cycles, required 0",
               multi_cnt + stray_cnt + clr_run_bad - bad0);
    end
  endtask

  task automatic test_retry_set();
    int s0, phase;
    logic [N-1:0] done_v, err_v;
    s0 = set_cnt; phase = 0; done_v = '0; err_v = '0;
    bus.op = 8'b00100000;
    bus.req = 4'b0100;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (phase == 0 && !bus.bank_set_) phase = 1;
      else if (phase == 1) begin bus.notifier = 1'b1; phase = 2; end
      else if (phase == 2) begin bus.notifier = 1'b0; phase = 3; end
      err_v = err_v | bus.err;
      if (bus.done != '0) begin
        done_v  = bus.done;
        bus.req = '0;
        break;
      end
    end
    bus.notifier = 1'b0;
    drain();
    vecs++;
    if (set_cnt - s0 != 2) begin
      errs++;
      $display("FAIL retry_set_strobes: %0d set strobes, required 2", set_cnt - s0);
    end
    vecs++;
    if (done_v !== 4'b0100 || err_v !== 4'b0000) begin
      errs++;
      $display("FAIL retry_set_result: done=%b err=%b, required 0100 0000", done_v, err_v);
    end
  endtask

  task automatic test_retry_exhaust();
    int l0;
    logic [N-1:0] done_v, err_v, first;
    l0 = ld_cnt; done_v = '0; err_v = '0; first = '0;
    bus.op = 8'b00000000;
    bus.wdata = 32'h000000FF;
    stuck = 1'b1; stuck_val = 8'h00;
    bus.req = 4'b0001;
    for (int k = 0; k < 60; k++) begin
      cyc();
      done_v = done_v | bus.done;
      if (bus.err != '0) begin
        err_v   = bus.err;
        bus.req = '0;
        break;
      end
    end
    stuck = 1'b0;
    vecs++;
    if (ld_cnt - l0 != 3) begin
      errs++;
      $display("FAIL exhaust_attempts: %0d load strobes, required 3", ld_cnt - l0);
    end
    vecs++;
    if (err_v !== 4'b0001 || done_v !== 4'b0000) begin
      errs++;
      $display("FAIL exhaust_result: err=%b done=%b, required 0001 0000", err_v, done_v);
    end
    bus.op = 8'b00001111;
    bus.req = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (bus.gnt != '0) begin
        first = bus.gnt;
        break;
      end
    end
    drain();
    vecs++;
    if (first !== 4'b0010) begin
      errs++;
      $display("FAIL exhaust_pointer: next grant=%b, required 0010", first);
    end
  endtask

  task automatic test_read();
    int done_at, st0;
    logic [N-1:0] done_v;
    done_at = -1; done_v = '0;
    st0 = ld_cnt + clr_cnt + set_cnt;
    stuck = 1'b1; stuck_val = 8'h3C;
    bus.op = 8'b11000000;
    bus.req = 4'b1000;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (bus.done != '0 && done_at < 0) begin
        done_at = k;
        done_v  = bus.done;
        bus.req = '0;
      end
    end
    stuck = 1'b0;
    vecs++;
    if (done_at != 3 || done_v !== 4'b1000) begin
      errs++;
      $display("FAIL read_done: done=%b after %0d edges, required 1000 after 2", done_v, done_at - 1);
    end
    vecs++;
    if (bus.rdata !== 8'h3C) begin
      errs++;
      $display("FAIL read_rdata: rdata=%h, required 3c", bus.rdata);
    end
    vecs++;
    if (ld_cnt + clr_cnt + set_cnt - st0 != 0) begin
      errs++;
      $display("FAIL read_strobes: %0d strobe cycles, required 0", ld_cnt + clr_cnt + set_cnt - st0);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] seen, first;
    seen = '0; first = '0;
    // Complete a read on requester 0 so the pointer sits at 1 before the abort.
    bus.op = 8'b00000011;
    bus.req = 4'b0001;
    drain();
    bus.wdata = 32'h005A0000;
    bus.req = 4'b0100;
    cyc(); cyc();
    vecs++;
    if (bus.busy !== 1'b1 || bus.gnt !== 4'b0100) begin
      errs++;
      $display("FAIL abort_precond: busy=%b gnt=%b, required 1 0100", bus.busy, bus.gnt);
    end
    clr = 1'b1;
    bus.req = 4'b0101;
    #1;
    vecs++;
    if ({bus.gnt, bus.done, bus.err, bus.busy} !== 13'b0 || bus.rdata !== 8'h00 || bus.bank_d !== 8'h00) begin
      errs++;
      $display("FAIL abort_async_ctrl: gnt=%b done=%b err=%b busy=%b rdata=%h bank_d=%h, required all 0",
               bus.gnt, bus.done, bus.err, bus.busy, bus.rdata, bus.bank_d);
    end
    vecs++;
    if ({bus.bank_ld, bus.bank_clr_, bus.bank_set_} !== 3'b011) begin
      errs++;
      $display("FAIL abort_async_strobes: ld/clr_/set_=%b, required 011", {bus.bank_ld, bus.bank_clr_, bus.bank_set_});
    end
    cyc(); seen = seen | bus.done | bus.err;
    cyc(); seen = seen | bus.done | bus.err;
    clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      seen = seen | bus.done | bus.err;
      if (bus.gnt != '0) begin
        first = bus.gnt;
        break;
      end
    end
    vecs++;
    if (seen !== 4'b0000) begin
      errs++;
      $display("FAIL abort_no_pulse: done|err=%b, required 0000", seen);
    end
    vecs++;
    if (first !== 4'b0001) begin
      errs++;
      $display("FAIL abort_regrant: first grant=%b, required 0001", first);
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    bus.req = '0; bus.op = '0; bus.wdata = '0; bus.notifier = 1'b0;
    test_reset();
    test_load();
    test_round_robin();
    test_retry_set();
    test_retry_exhaust();
    test_read();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
